control_sequencer: RTL and testbench

- Moore-style hardwired control unit for the MiniSRC datapath.
- Steps through fetch and execute timing states and decodes the opcode in IR[31:27].
- Drives the bus-select, register-enable and memory strobes.
- Drives Gra/Grb/Grc/Rin/Rout/BAout/Cout directly into the register select-and-encode stage, which turns them into per-register enables.

---
 rtl/control_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: Moore hardwired control unit for the MiniSRC datapath.
// Fetch runs T0-T2; the opcode in IR[31:27] picks the execute steps T3-T7.
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        run,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t state_q, state_d, last_st;
    logic [4:0] op;
    logic is_ld, is_ldi, is_st, is_rr, is_imm, is_md, is_nn, is_br;
    logic is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt, is_mem;
    logic unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign is_ld     = op == 5'b00000;
    assign is_ldi    = op == 5'b00001;
    assign is_st     = op == 5'b00010;
    assign is_rr     = op >= 5'b00011 && op <= 5'b01010;
    assign is_imm    = op >= 5'b01011 && op <= 5'b01101;
    assign is_md     = op == 5'b01110 || op == 5'b01111;
    assign is_nn     = op == 5'b10000 || op == 5'b10001;
    assign is_br     = op == 5'b10010;
    assign is_jr     = op == 5'b10011;
    assign is_in     = op == 5'b10101;
    assign is_out    = op == 5'b10110;
    assign is_mfhi   = op == 5'b10111;
    assign is_mflo   = op == 5'b11000;
    assign is_halt   = op == 5'b11010;
    assign is_mem    = is_ld || is_ldi || is_st;

    // Final execute step per instruction class; everything else ends at T3.
    always_comb begin
        last_st = S_T3;
        if (is_rr || is_imm || is_ldi)
            last_st = S_T5;
        else if (is_md || is_br)
            last_st = S_T6;
        else if (is_ld || is_st)
            last_st = S_T7;
        else if (is_nn)
            last_st = S_T4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_T0;
            S_T0:    state_d = stop ? S_HALT : S_T1;
            S_HALT:  state_d = S_HALT;
            default: state_d = (state_q == S_T3 && is_halt) ? S_HALT :
                               (state_q == last_st) ? S_T0 :
                               state_t'(state_q + 4'd1);
        endcase
    end

    always_comb begin
        run       = 1'b0;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        InPortout = 1'b0;
        Cout      = 1'b0;
        PCin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        OutPortin = 1'b0;
        CONin     = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        BAout     = 1'b0;
        alu_op    = 5'b00000;
        case (state_q)
            S_T0: begin
                run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (is_rr || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_md) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_nn) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (is_in) begin
                    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_out) begin
                    Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
                end else if (is_mfhi) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_mflo) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T4: begin
                run = 1'b1;
                if (is_rr) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (is_md) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (is_nn) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_mem) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                run = 1'b1;
                if (is_rr || is_imm || is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_md) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP;
                end
            end
            S_T6: begin
                run = 1'b1;
                if (is_md) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end else if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br) begin
                    Zlowout = 1'b1; PCin = CON_FF;
                end
            end
            S_T7: begin
                run = 1'b1;
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: vector table of per-cycle control words checked through a scoreboard,
// plus hand sequences for stop/halt, halt opcode and asynchronous reset during a store.
module tb_control_sequencer;
    logic clk, reset, stop, CON_FF;
    logic [31:0] IR;
    logic run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] alu_op;
    logic [32:0] cw;

    int checks = 0;
    int errors = 0;

    localparam logic [32:0] BAO  = 33'd1 << 5,  RO   = 33'd1 << 6,  RIN  = 33'd1 << 7;
    localparam logic [32:0] GRC  = 33'd1 << 8,  GRB  = 33'd1 << 9,  GRA  = 33'd1 << 10;
    localparam logic [32:0] WR   = 33'd1 << 11, RD   = 33'd1 << 12, INC  = 33'd1 << 13;
    localparam logic [32:0] CONI = 33'd1 << 14, OUTI = 33'd1 << 15, LOI  = 33'd1 << 16;
    localparam logic [32:0] HII  = 33'd1 << 17, ZIN  = 33'd1 << 18, YIN  = 33'd1 << 19;
    localparam logic [32:0] IRI  = 33'd1 << 20, MDRI = 33'd1 << 21, MARI = 33'd1 << 22;
    localparam logic [32:0] PCI  = 33'd1 << 23, CO   = 33'd1 << 24, INPO = 33'd1 << 25;
    localparam logic [32:0] LOO  = 33'd1 << 26, HIO  = 33'd1 << 27, MDRO = 33'd1 << 28;
    localparam logic [32:0] ZHO  = 33'd1 << 29, ZLO  = 33'd1 << 30, PCO  = 33'd1 << 31;
    localparam logic [32:0] RUN  = 33'd1 << 32, ADDA = 33'd3;
    localparam logic [32:0] F0 = RUN | PCO | MARI | INC | ZIN;
    localparam logic [32:0] F1 = RUN | ZLO | PCI | RD | MDRI;
    localparam logic [32:0] F2 = RUN | MDRO | IRI;

    localparam logic [31:0] I_ADD = 32'h18918000, I_LD  = 32'h01000055, I_LDI = 32'h08000000;
    localparam logic [31:0] I_ST  = 32'h10000000, I_ADDI = 32'h58000000, I_MUL = 32'h71A00000;
    localparam logic [31:0] I_NEG = 32'h80000000, I_BR  = 32'h90000000, I_JR  = 32'h98000000;
    localparam logic [31:0] I_IN  = 32'hA8000000, I_OUT = 32'hB0000000, I_MFHI = 32'hB8000000;
    localparam logic [31:0] I_MFLO = 32'hC0000000, I_NOP = 32'hC8000000, I_HALT = 32'hD0000000;
    localparam logic [31:0] I_UND = 32'hF8000000;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stp;
        logic [32:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [32:0] sb[$];

    control_sequencer dut (
        .clk(clk), .reset(reset), .stop(stop), .IR(IR), .CON_FF(CON_FF), .run(run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op)
    );

    assign cw = {run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
                 PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin,
                 IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (!$onehot0({PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout})) begin
            errors++;
            $display("FAIL bus_onehot t=%0t: drivers %b, required at most one", $time,
                     {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic row(input logic [31:0] ir, input logic con, input logic stp, input logic [32:0] exp);
        vec_t v;
        v.ir = ir; v.con = con; v.stp = stp; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] ir, input logic con);
        row(ir, con, 1'b0, F0);
        row(ir, con, 1'b0, F1);
        row(ir, con, 1'b0, F2);
    endtask

    task automatic check_cw(input string name);
        logic [32:0] exp;
        exp = sb.pop_front();
        checks++;
        if (cw !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, cw, exp);
        end
    endtask

    task automatic step(input logic [31:0] ir, input logic stp, input logic [32:0] exp, input string name);
        @(negedge clk);
        IR = ir; stop = stp;
        sb.push_back(exp);
        #1 check_cw(name);
    endtask

    initial begin
        reset = 1'b0; stop = 1'b0; CON_FF = 1'b0; IR = 32'h0;
        // stop held high outside T0 must not halt
        row(I_ADD, 0, 0, F0); row(I_ADD, 0, 1, F1); row(I_ADD, 0, 1, F2);
        row(I_ADD, 0, 1, RUN | GRB | RO | YIN);
        row(I_ADD, 0, 1, RUN | GRC | RO | ZIN | ADDA);
        row(I_ADD, 0, 0, RUN | ZLO | GRA | RIN);
        fetch(I_LD, 0);
        row(I_LD, 0, 0, RUN | GRB | BAO | YIN);
        row(I_LD, 0, 0, RUN | CO | ZIN | ADDA);
        row(I_LD, 0, 0, RUN | ZLO | MARI);
        row(I_LD, 0, 0, RUN | RD | MDRI);
        row(I_LD, 0, 0, RUN | MDRO | GRA | RIN);
        for (int c = 0; c < 2; c++) begin
            fetch(I_BR, c[0]);
            row(I_BR, c[0], 0, RUN | GRA | RO | CONI);
            row(I_BR, c[0], 0, RUN | PCO | YIN);
            row(I_BR, c[0], 0, RUN | CO | ZIN | ADDA);
            row(I_BR, c[0], 0, RUN | ZLO | (c[0] ? PCI : 33'd0));
        end
        fetch(I_MUL, 0);
        row(I_MUL, 0, 0, RUN | GRA | RO | YIN);
        row(I_MUL, 0, 0, RUN | GRB | RO | ZIN | 33'h0E);
        row(I_MUL, 0, 0, RUN | ZLO | LOI);
        row(I_MUL, 0, 0, RUN | ZHO | HII);
        fetch(I_ADDI, 0);
        row(I_ADDI, 0, 0, RUN | GRB | RO | YIN);
        row(I_ADDI, 0, 0, RUN | CO | ZIN | 33'h0B);
        row(I_ADDI, 0, 0, RUN | ZLO | GRA | RIN);
        fetch(I_NEG, 0);
        row(I_NEG, 0, 0, RUN | GRB | RO | ZIN | 33'h10);
        row(I_NEG, 0, 0, RUN | ZLO | GRA | RIN);
        fetch(I_LDI, 0);
        row(I_LDI, 0, 0, RUN | GRB | BAO | YIN);
        row(I_LDI, 0, 0, RUN | CO | ZIN | ADDA);
        row(I_LDI, 0, 0, RUN | ZLO | GRA | RIN);
        fetch(I_ST, 0);
        row(I_ST, 0, 0, RUN | GRB | BAO | YIN);
        row(I_ST, 0, 0, RUN | CO | ZIN | ADDA);
        row(I_ST, 0, 0, RUN | ZLO | MARI);
        row(I_ST, 0, 0, RUN | GRA | RO | MDRI);
        row(I_ST, 0, 0, RUN | WR);
        fetch(I_JR, 0);   row(I_JR, 0, 0, RUN | GRA | RO | PCI);
        fetch(I_IN, 0);   row(I_IN, 0, 0, RUN | INPO | GRA | RIN);
        fetch(I_OUT, 0);  row(I_OUT, 0, 0, RUN | GRA | RO | OUTI);
        fetch(I_MFHI, 0); row(I_MFHI, 0, 0, RUN | HIO | GRA | RIN);
        fetch(I_MFLO, 0); row(I_MFLO, 0, 0, RUN | LOO | GRA | RIN);
        fetch(I_NOP, 0);  row(I_NOP, 0, 0, RUN);
        fetch(I_UND, 0);  row(I_UND, 0, 0, RUN);

        repeat (2) @(negedge clk);
        sb.push_back(33'd0);
        check_cw("reset_held");
        reset = 1'b1;
        sb.push_back(33'd0);
        #1 check_cw("rst_state");

        foreach (vecs[i]) begin
            @(negedge clk);
            IR = vecs[i].ir; CON_FF = vecs[i].con; stop = vecs[i].stp;
            sb.push_back(vecs[i].exp);
            #1 check_cw($sformatf("row%0d_ir%h", i, vecs[i].ir));
        end

        step(I_NOP, 1'b1, F0, "t0_stop");
        step(I_NOP, 1'b0, 33'd0, "halt_entry");
        for (int k = 0; k < 20; k++)
            step(I_NOP, 1'b0, 33'd0, "halt_hold");
        reset = 1'b0;
        sb.push_back(33'd0);
        #1 check_cw("halt_reset");
        @(negedge clk);
        reset = 1'b1;
        step(I_HALT, 1'b0, F0, "recover_t0");
        step(I_HALT, 1'b0, F1, "halt_op_t1");
        step(I_HALT, 1'b0, F2, "halt_op_t2");
        step(I_HALT, 1'b0, RUN, "halt_op_t3");
        step(I_HALT, 1'b0, 33'd0, "halt_op_halted");
        step(I_HALT, 1'b0, 33'd0, "halt_op_hold");
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(I_ST, 1'b0, F0, "st_t0");
        step(I_ST, 1'b0, F1, "st_t1");
        step(I_ST, 1'b0, F2, "st_t2");
        step(I_ST, 1'b0, RUN | GRB | BAO | YIN, "st_t3");
        step(I_ST, 1'b0, RUN | CO | ZIN | ADDA, "st_t4");
        step(I_ST, 1'b0, RUN | ZLO | MARI, "st_t5");
        step(I_ST, 1'b0, RUN | GRA | RO | MDRI, "st_t6");
        step(I_ST, 1'b0, RUN | WR, "st_t7");
        #2 reset = 1'b0;
        sb.push_back(33'd0);
        #1 check_cw("st_async_reset");
        step(I_ST, 1'b0, 33'd0, "st_reset_hold");
        reset = 1'b1;
        step(I_ST, 1'b0, F0, "st_recover_t0");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
